// File: rtl/axis_pkt_header_parser_p.sv
// ---------------------------------------------------------------------------
// axis_pkt_header_parser_p
//
// Purpose:
//   AXI-Stream header parser/stripper between the DMA MM2S port and the
//   stream-to-BRAM datapath. It captures HDR_WORDS header words and checks
//   word 0 against MAGIC. It registers the control fields (instruction,
//   BRAM range, address start/count) and forwards only the payload
//   downstream. The declared payload length (addr_count) is enforced:
//   m_axis_tlast is forced on the last declared beat, and any surplus input
//   beats are drained.
//
// Optional feature (macro HDR_CHECKSUM_EN):
//   When defined, header word HDR_WORDS-1 must equal the XOR of words
//   0..HDR_WORDS-2 (full DATA_WIDTH). On a mismatch err_checksum pulses, the
//   fields are left untouched and the rest of the packet is drained.
//   When undefined, no check is made and err_checksum stays 0.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             input stream (header + payload)
//   m_axis_*             payload stream (combinational pass-through)
//   instruction_code     header word1[7:0]
//   bram_start/bram_end  header word2/word3 [BRAM_SEL_W-1:0]
//   addr_start           header word4[15:0]
//   addr_count           header word5[15:0], declared payload beats
//   header_valid         pulse, fields updated
//   pkt_done             pulse, payload completed
//   err_*                pulses: magic, short header, length, checksum
//   beat_count           payload beats forwarded in current packet
//   state_dbg            FSM state (IDLE=0, HDR=1, PAYLOAD=2, DRAIN=3)
//
// Handshake: a beat transfers on a channel in the cycle where tvalid and
//   tready are both high at the rising edge of aclk. Outside PAYLOAD, the
//   input is always ready. In PAYLOAD, s_axis_tready is m_axis_tready and
//   m_axis_tvalid is s_axis_tvalid, so a beat moves through in one step.
// ---------------------------------------------------------------------------
module axis_pkt_header_parser_p #(
    parameter int          DATA_WIDTH = 16,
    parameter int          HDR_WORDS  = 6,
    parameter logic [15:0] MAGIC      = 16'hA5A5,
    parameter int          BRAM_SEL_W = 5
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            instruction_code,
    output logic [BRAM_SEL_W-1:0] bram_start,
    output logic [BRAM_SEL_W-1:0] bram_end,
    output logic [15:0]           addr_start,
    output logic [15:0]           addr_count,
    output logic                  header_valid,
    output logic                  pkt_done,
    output logic                  err_magic,
    output logic                  err_short_hdr,
    output logic                  err_len,
    output logic                  err_checksum,
    output logic [15:0]           beat_count,
    output logic [2:0]            state_dbg
);

    localparam int               CNT_W    = $clog2(HDR_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_hdr_cnt;
    logic [CNT_W-1:0]      w_hdr_cnt_nxt;

    // Shadow copies of the header fields, filled as words arrive. They are
    // only copied to the visible fields when the whole header is accepted.
    logic [7:0]            r_sh_instr;
    logic [BRAM_SEL_W-1:0] r_sh_bstart;
    logic [BRAM_SEL_W-1:0] r_sh_bend;
    logic [15:0]           r_sh_astart;
    logic [15:0]           r_sh_acount;
    logic [7:0]            w_sh_instr_nxt;
    logic [BRAM_SEL_W-1:0] w_sh_bstart_nxt;
    logic [BRAM_SEL_W-1:0] w_sh_bend_nxt;
    logic [15:0]           w_sh_astart_nxt;
    logic [15:0]           w_sh_acount_nxt;

    logic [7:0]            r_instr;
    logic [BRAM_SEL_W-1:0] r_bstart;
    logic [BRAM_SEL_W-1:0] r_bend;
    logic [15:0]           r_astart;
    logic [15:0]           r_acount;
    logic [15:0]           r_beat_count;

    logic                  r_header_valid;
    logic                  r_pkt_done;
    logic                  r_err_magic;
    logic                  r_err_short;
    logic                  r_err_len;
    logic                  r_err_cks;

    logic                  w_header_valid;
    logic                  w_pkt_done;
    logic                  w_err_magic;
    logic                  w_err_short;
    logic                  w_err_len;
    logic                  w_err_cks;
    logic                  w_load_fields;
    logic                  w_beat_inc;

    logic                  w_in_payload;
    logic                  w_s_hs;
    logic                  w_hdr_last;
    logic                  w_count_hit;
    logic                  w_cks_ok;

    // -----------------------------------------------------------------------
    // Stream plumbing. Everything is gated by aresetn so that the outputs
    // are quiet while reset is held, even before the first reset edge.
    // -----------------------------------------------------------------------
    assign w_in_payload  = aresetn && (r_state == ST_PAYLOAD);
    assign s_axis_tready = aresetn && ((r_state == ST_PAYLOAD) ? m_axis_tready : 1'b1);
    assign m_axis_tvalid = w_in_payload && s_axis_tvalid;
    assign m_axis_tdata  = w_in_payload ? s_axis_tdata : '0;
    assign w_count_hit   = (r_beat_count == (r_acount - 16'd1));
    assign m_axis_tlast  = w_in_payload && (s_axis_tlast || w_count_hit);

    // In PAYLOAD the input and output handshakes are the same event.
    assign w_s_hs     = s_axis_tvalid && s_axis_tready;
    assign w_hdr_last = (r_hdr_cnt == LAST_IDX);

`ifdef HDR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_xor;

    // Running XOR of header words 0..HDR_WORDS-2. Word 0 seeds it in IDLE.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_xor <= '0;
        end else if (w_s_hs && (r_state == ST_IDLE)) begin
            r_xor <= s_axis_tdata;
        end else if (w_s_hs && (r_state == ST_HDR) && !w_hdr_last) begin
            r_xor <= r_xor ^ s_axis_tdata;
        end
    end

    assign w_cks_ok = (s_axis_tdata == r_xor);
`else
    assign w_cks_ok = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Shadow capture. Words beyond 5 are ignored. The checksum word is
    // handled separately.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sh_instr_nxt  = r_sh_instr;
        w_sh_bstart_nxt = r_sh_bstart;
        w_sh_bend_nxt   = r_sh_bend;
        w_sh_astart_nxt = r_sh_astart;
        w_sh_acount_nxt = r_sh_acount;
        if (w_s_hs && (r_state == ST_HDR)) begin
            if (r_hdr_cnt == CNT_W'(1)) w_sh_instr_nxt  = s_axis_tdata[7:0];
            if (r_hdr_cnt == CNT_W'(2)) w_sh_bstart_nxt = s_axis_tdata[BRAM_SEL_W-1:0];
            if (r_hdr_cnt == CNT_W'(3)) w_sh_bend_nxt   = s_axis_tdata[BRAM_SEL_W-1:0];
            if (r_hdr_cnt == CNT_W'(4)) w_sh_astart_nxt = s_axis_tdata[15:0];
            if (r_hdr_cnt == CNT_W'(5)) w_sh_acount_nxt = s_axis_tdata[15:0];
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and pulse decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_hdr_cnt_nxt  = r_hdr_cnt;
        w_header_valid = 1'b0;
        w_pkt_done     = 1'b0;
        w_err_magic    = 1'b0;
        w_err_short    = 1'b0;
        w_err_len      = 1'b0;
        w_err_cks      = 1'b0;
        w_load_fields  = 1'b0;
        w_beat_inc     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_s_hs) begin
                    if (s_axis_tdata[15:0] != MAGIC) begin
                        w_err_magic = 1'b1;
                        w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else if (s_axis_tlast) begin
                        // Good magic but the packet ended at word 0.
                        w_err_short = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hdr_cnt_nxt = CNT_W'(1);
                        w_state_nxt   = ST_HDR;
                    end
                end
            end

            ST_HDR: begin
                if (w_s_hs) begin
                    if (!w_hdr_last) begin
                        if (s_axis_tlast) begin
                            w_err_short = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_hdr_cnt_nxt = r_hdr_cnt + CNT_W'(1);
                        end
                    end else if (!w_cks_ok) begin
                        w_err_cks   = 1'b1;
                        w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        w_load_fields  = 1'b1;
                        w_header_valid = 1'b1;
                        if (w_sh_acount_nxt == 16'd0) begin
                            if (s_axis_tlast) begin
                                w_pkt_done  = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_err_len   = 1'b1;
                                w_state_nxt = ST_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            // Payload declared but the packet has none.
                            w_err_len   = 1'b1;
                            w_pkt_done  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                if (w_s_hs) begin
                    w_beat_inc = 1'b1;
                    if (w_count_hit) begin
                        w_pkt_done = 1'b1;
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_len   = 1'b1;
                            w_state_nxt = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        w_pkt_done  = 1'b1;
                        w_err_len   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_s_hs && s_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, fields, counters and registered pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_hdr_cnt      <= '0;
            r_sh_instr     <= '0;
            r_sh_bstart    <= '0;
            r_sh_bend      <= '0;
            r_sh_astart    <= '0;
            r_sh_acount    <= '0;
            r_instr        <= '0;
            r_bstart       <= '0;
            r_bend         <= '0;
            r_astart       <= '0;
            r_acount       <= '0;
            r_beat_count   <= '0;
            r_header_valid <= 1'b0;
            r_pkt_done     <= 1'b0;
            r_err_magic    <= 1'b0;
            r_err_short    <= 1'b0;
            r_err_len      <= 1'b0;
            r_err_cks      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hdr_cnt      <= w_hdr_cnt_nxt;
            r_sh_instr     <= w_sh_instr_nxt;
            r_sh_bstart    <= w_sh_bstart_nxt;
            r_sh_bend      <= w_sh_bend_nxt;
            r_sh_astart    <= w_sh_astart_nxt;
            r_sh_acount    <= w_sh_acount_nxt;
            r_header_valid <= w_header_valid;
            r_pkt_done     <= w_pkt_done;
            r_err_magic    <= w_err_magic;
            r_err_short    <= w_err_short;
            r_err_len      <= w_err_len;
            r_err_cks      <= w_err_cks;
            if (w_load_fields) begin
                r_instr  <= w_sh_instr_nxt;
                r_bstart <= w_sh_bstart_nxt;
                r_bend   <= w_sh_bend_nxt;
                r_astart <= w_sh_astart_nxt;
                r_acount <= w_sh_acount_nxt;
            end
            // The count restarts with the header so that it reads 0 in the
            // same cycle that header_valid is high.
            if (w_load_fields) begin
                r_beat_count <= '0;
            end else if (w_beat_inc) begin
                r_beat_count <= r_beat_count + 16'd1;
            end
        end
    end

    assign instruction_code = r_instr;
    assign bram_start       = r_bstart;
    assign bram_end         = r_bend;
    assign addr_start       = r_astart;
    assign addr_count       = r_acount;
    assign beat_count       = r_beat_count;
    assign header_valid     = r_header_valid;
    assign pkt_done         = r_pkt_done;
    assign err_magic        = r_err_magic;
    assign err_short_hdr    = r_err_short;
    assign err_len          = r_err_len;
    assign err_checksum     = r_err_cks;
    assign state_dbg        = r_state;

endmodule

// File: tb/tb_axis_pkt_header_parser_p.sv
module tb_axis_pkt_header_parser_p;

`ifdef HDR_CHECKSUM_EN
  localparam int HW = 7;
`else
  localparam int HW = 6;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  instruction_code;
  logic [4:0]  bram_start;
  logic [4:0]  bram_end;
  logic [15:0] addr_start;
  logic [15:0] addr_count;
  logic        header_valid;
  logic        pkt_done;
  logic        err_magic;
  logic        err_short_hdr;
  logic        err_len;
  logic        err_checksum;
  logic [15:0] beat_count;
  logic [2:0]  state_dbg;

  axis_pkt_header_parser_p #(
    .DATA_WIDTH(16),
    .HDR_WORDS (HW),
    .MAGIC     (16'hA5A5),
    .BRAM_SEL_W(5)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .instruction_code(instruction_code),
    .bram_start      (bram_start),
    .bram_end        (bram_end),
    .addr_start      (addr_start),
    .addr_count      (addr_count),
    .header_valid    (header_valid),
    .pkt_done        (pkt_done),
    .err_magic       (err_magic),
    .err_short_hdr   (err_short_hdr),
    .err_len         (err_len),
    .err_checksum    (err_checksum),
    .beat_count      (beat_count),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // monitor state
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        got_last_q[$];
  int hv_n, done_n, emag_n, eshort_n, elen_n, ecks_n, mvalid_n, mirror_n, stall_n;
  int ecks_total = 0;
  logic bp_mode = 1'b0;
  logic bp_tog = 1'b1;

  // Samples 1 ns before each rising edge, when all inputs are settled.
  always begin
    @(negedge aclk);
    #4;
    if (header_valid) hv_n++;
    if (pkt_done) done_n++;
    if (err_magic) emag_n++;
    if (err_short_hdr) eshort_n++;
    if (err_len) elen_n++;
    if (err_checksum) begin ecks_n++; ecks_total++; end
    if (m_axis_tvalid) mvalid_n++;
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(m_axis_tdata);
      got_last_q.push_back(m_axis_tlast);
    end
    if (state_dbg == 3'd2 && s_axis_tready !== m_axis_tready) mirror_n++;
    if (state_dbg == 3'd2 && s_axis_tvalid && !s_axis_tready) stall_n++;
  end

  task automatic clear_mon();
    hv_n = 0; done_n = 0; emag_n = 0; eshort_n = 0; elen_n = 0; ecks_n = 0;
    mvalid_n = 0; mirror_n = 0; stall_n = 0;
    got_q.delete(); got_last_q.delete(); exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // driver: called at a negedge, returns at the negedge after the handshake
  task automatic send_beat(input logic [15:0] d, input logic l);
    int   guard;
    logic rdy;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    forever begin
      if (bp_mode) begin
        m_axis_tready = bp_tog;
        bp_tog = ~bp_tog;
      end else begin
        m_axis_tready = 1'b1;
      end
      #1;
      rdy = s_axis_tready;
      @(posedge aclk);
      @(negedge aclk);
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        checks++; errors++;
        $display("FAIL send_beat_timeout: data %h never accepted, required accept within 50 cycles", d);
        break;
      end
    end
  endtask

  task automatic end_stream();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    idle(4);
  endtask

  task automatic send_hdr(input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3,
                          input logic [15:0] w4, input logic [15:0] w5, input logic last,
                          input logic bad_cks);
    logic [15:0] w [0:6];
    logic [15:0] x;
    w[0] = 16'hA5A5; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5; w[6] = 16'h0000;
    x = 16'h0000;
    for (int i = 0; i < HW - 1; i++) x = x ^ w[i];
`ifdef HDR_CHECKSUM_EN
    w[HW-1] = bad_cks ? (x ^ 16'h0100) : x;
`endif
    for (int i = 0; i < HW; i++) send_beat(w[i], last && (i == HW - 1));
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'hA5A5;
    idle(3);
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b exp 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    checks++; if ({instruction_code, bram_start, bram_end, addr_start, addr_count, beat_count} !== '0) begin
      errors++; $display("FAIL reset_fields: got nonzero field/counter");
    end
    checks++; if ({header_valid, pkt_done, err_magic, err_short_hdr, err_len, err_checksum} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses: got %b exp 000000",
        {header_valid, pkt_done, err_magic, err_short_hdr, err_len, err_checksum});
    end
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_mon();
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_hdr(16'h0001, 16'h0000, 16'h000F, 16'h0000, 16'h0004, 1'b0, 1'b0);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b0);
    send_beat(16'h4444, 1'b1);
    end_stream();
    checks++; if (hv_n !== 1) begin errors++; $display("FAIL basic_hv: got %0d exp 1", hv_n); end
    checks++; if (instruction_code !== 8'h01) begin errors++; $display("FAIL basic_instr: got %h exp 01", instruction_code); end
    checks++; if (bram_end !== 5'h0F) begin errors++; $display("FAIL basic_bram_end: got %h exp 0f", bram_end); end
    checks++; if (addr_count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d exp 4", addr_count); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_nbeats: got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_last_q[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b exp %b", i, got_last_q[i], i == 3); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done: got %0d exp 1", done_n); end
    checks++; if (elen_n !== 0) begin errors++; $display("FAIL basic_errlen: got %0d exp 0", elen_n); end
    checks++; if (beat_count !== 16'd4) begin errors++; $display("FAIL basic_beat_count: got %0d exp 4", beat_count); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL basic_state: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_bad_magic();
    clear_mon();
    send_beat(16'h1234, 1'b0);
    for (int i = 0; i < 9; i++) send_beat(16'h0100 + 16'(i), i == 8);
    end_stream();
    checks++; if (emag_n !== 1) begin errors++; $display("FAIL magic_err: got %0d exp 1", emag_n); end
    checks++; if (mvalid_n !== 0) begin errors++; $display("FAIL magic_mvalid: got %0d exp 0", mvalid_n); end
    checks++; if (hv_n !== 0) begin errors++; $display("FAIL magic_hv: got %0d exp 0", hv_n); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL magic_state: got %0d exp 0", state_dbg); end
    clear_mon();
    exp_q = '{16'hAAAA, 16'hBBBB};
    send_hdr(16'h0002, 16'h0001, 16'h0002, 16'h0010, 16'h0002, 1'b0, 1'b0);
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b1);
    end_stream();
    checks++; if (hv_n !== 1) begin errors++; $display("FAIL magic_next_hv: got %0d exp 1", hv_n); end
    checks++; if (instruction_code !== 8'h02) begin errors++; $display("FAIL magic_next_instr: got %h exp 02", instruction_code); end
    checks++; if (addr_start !== 16'h0010) begin errors++; $display("FAIL magic_next_astart: got %h exp 0010", addr_start); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL magic_next_nbeats: got %0d exp 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL magic_next_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL magic_next_done: got %0d exp 1", done_n); end
  endtask

  task automatic test_len_short();
    clear_mon();
    exp_q = '{16'hC000, 16'hC001, 16'hC002};
    send_hdr(16'h0003, 16'h0000, 16'h0001, 16'h0000, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_beat(16'hC000 + 16'(i), i == 5);
    end_stream();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL lshort_nbeats: got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lshort_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_last_q[i] !== (i == 2)) begin errors++; $display("FAIL lshort_last[%0d]: got %b exp %b", i, got_last_q[i], i == 2); end
    end
    checks++; if (elen_n !== 1) begin errors++; $display("FAIL lshort_errlen: got %0d exp 1", elen_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL lshort_done: got %0d exp 1", done_n); end
    checks++; if (beat_count !== 16'd3) begin errors++; $display("FAIL lshort_beat_count: got %0d exp 3", beat_count); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL lshort_state: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_len_long();
    clear_mon();
    exp_q = '{16'hD000, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
    send_hdr(16'h0004, 16'h0000, 16'h0001, 16'h0000, 16'h0008, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(16'hD000 + 16'(i), i == 4);
    end_stream();
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL llong_nbeats: got %0d exp 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL llong_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_last_q[i] !== (i == 4)) begin errors++; $display("FAIL llong_last[%0d]: got %b exp %b", i, got_last_q[i], i == 4); end
    end
    checks++; if (elen_n !== 1) begin errors++; $display("FAIL llong_errlen: got %0d exp 1", elen_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL llong_done: got %0d exp 1", done_n); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL llong_state: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_short_hdr();
    clear_mon();
    send_beat(16'hA5A5, 1'b0);
    send_beat(16'h0077, 1'b0);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b1);
    end_stream();
    checks++; if (eshort_n !== 1) begin errors++; $display("FAIL shdr_err: got %0d exp 1", eshort_n); end
    checks++; if (hv_n !== 0) begin errors++; $display("FAIL shdr_hv: got %0d exp 0", hv_n); end
    checks++; if (instruction_code !== 8'h04) begin errors++; $display("FAIL shdr_instr_kept: got %h exp 04", instruction_code); end
    checks++; if (addr_count !== 16'd8) begin errors++; $display("FAIL shdr_count_kept: got %0d exp 8", addr_count); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL shdr_state: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_zero_count();
    // count 0, tlast on last header word
    clear_mon();
    send_hdr(16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    end_stream();
    checks++; if (hv_n !== 1) begin errors++; $display("FAIL zero_hv: got %0d exp 1", hv_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_done: got %0d exp 1", done_n); end
    checks++; if (elen_n !== 0) begin errors++; $display("FAIL zero_errlen: got %0d exp 0", elen_n); end
    checks++; if (addr_count !== 16'd0) begin errors++; $display("FAIL zero_count: got %0d exp 0", addr_count); end
    // count 0, no tlast: one beat drained
    clear_mon();
    send_hdr(16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    send_beat(16'hE000, 1'b1);
    end_stream();
    checks++; if (elen_n !== 1) begin errors++; $display("FAIL zero_drain_errlen: got %0d exp 1", elen_n); end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL zero_drain_done: got %0d exp 0", done_n); end
    checks++; if (mvalid_n !== 0) begin errors++; $display("FAIL zero_drain_mvalid: got %0d exp 0", mvalid_n); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL zero_drain_state: got %0d exp 0", state_dbg); end
    // count 2 but tlast on last header word
    clear_mon();
    send_hdr(16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0);
    end_stream();
    checks++; if (elen_n !== 1) begin errors++; $display("FAIL nopay_errlen: got %0d exp 1", elen_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL nopay_done: got %0d exp 1", done_n); end
    checks++; if (instruction_code !== 8'h07) begin errors++; $display("FAIL nopay_instr: got %h exp 07", instruction_code); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    exp_q = '{16'hF000, 16'hF001, 16'hF002, 16'hF003};
    bp_mode = 1'b1;
    bp_tog = 1'b1;
    send_hdr(16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(16'hF000 + 16'(i), i == 3);
    bp_mode = 1'b0;
    end_stream();
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_nbeats: got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_last_q[i] !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b exp %b", i, got_last_q[i], i == 3); end
    end
    checks++; if (mirror_n !== 0) begin errors++; $display("FAIL bp_mirror: got %0d mismatching cycles exp 0", mirror_n); end
    checks++; if (stall_n < 3) begin errors++; $display("FAIL bp_stalls: got %0d exp >= 3", stall_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL bp_done: got %0d exp 1", done_n); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_hdr(16'h0009, 16'h0003, 16'h0004, 16'h1234, 16'h0006, 1'b0, 1'b0);
    send_beat(16'h9000, 1'b0);
    send_beat(16'h9001, 1'b0);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL rmid_pre_state: got %0d exp 2", state_dbg); end
    clear_mon();
    s_axis_tdata = 16'h9002;
    s_axis_tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_mvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rmid_tready: got %b exp 0", s_axis_tready); end
    @(negedge aclk);
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rmid_state: got %0d exp 0", state_dbg); end
    checks++; if ({instruction_code, addr_count, addr_start, beat_count} !== '0) begin
      errors++; $display("FAIL rmid_fields: got instr %h count %0d astart %h beats %0d exp all 0",
        instruction_code, addr_count, addr_start, beat_count);
    end
    checks++; if (m_axis_tdata !== 16'h0000) begin errors++; $display("FAIL rmid_mdata: got %h exp 0000", m_axis_tdata); end
    s_axis_tvalid = 1'b0;
    aresetn = 1'b1;
    idle(4);
    checks++; if (emag_n + eshort_n + elen_n + ecks_n + done_n + hv_n !== 0) begin
      errors++; $display("FAIL rmid_no_pulse: got %0d pulses exp 0", emag_n + eshort_n + elen_n + ecks_n + done_n + hv_n);
    end
    clear_mon();
    send_hdr(16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
    send_beat(16'h7777, 1'b1);
    end_stream();
    checks++; if (hv_n !== 1) begin errors++; $display("FAIL rmid_after_hv: got %0d exp 1", hv_n); end
    checks++; if (got_q.size() !== 1 || got_q[0] !== 16'h7777) begin
      errors++; $display("FAIL rmid_after_data: got %0d beats exp 1 beat 7777", got_q.size());
    end
  endtask

  task automatic test_checksum();
`ifdef HDR_CHECKSUM_EN
    clear_mon();
    send_hdr(16'h000B, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b1);
    send_beat(16'h6000, 1'b0);
    send_beat(16'h6001, 1'b1);
    end_stream();
    checks++; if (ecks_n !== 1) begin errors++; $display("FAIL cks_bad_err: got %0d exp 1", ecks_n); end
    checks++; if (hv_n !== 0) begin errors++; $display("FAIL cks_bad_hv: got %0d exp 0", hv_n); end
    checks++; if (mvalid_n !== 0) begin errors++; $display("FAIL cks_bad_mvalid: got %0d exp 0", mvalid_n); end
    checks++; if (instruction_code !== 8'h0A) begin errors++; $display("FAIL cks_bad_instr_kept: got %h exp 0a", instruction_code); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL cks_bad_state: got %0d exp 0", state_dbg); end
    clear_mon();
    send_hdr(16'h000C, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
    send_beat(16'h6100, 1'b1);
    end_stream();
    checks++; if (ecks_n !== 0) begin errors++; $display("FAIL cks_good_err: got %0d exp 0", ecks_n); end
    checks++; if (hv_n !== 1) begin errors++; $display("FAIL cks_good_hv: got %0d exp 1", hv_n); end
    checks++; if (instruction_code !== 8'h0C) begin errors++; $display("FAIL cks_good_instr: got %h exp 0c", instruction_code); end
`else
    checks++; if (ecks_total !== 0) begin errors++; $display("FAIL cks_disabled: got %0d pulses exp 0", ecks_total); end
`endif
  endtask

  initial begin
    @(negedge aclk);
    test_reset();
    test_basic();
    test_bad_magic();
    test_len_short();
    test_len_long();
    test_short_hdr();
    test_zero_count();
    test_backpressure();
    test_reset_mid();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
